// File: rtl/draw_port_arbiter_pkg.sv
// Screen geometry, palette and arbiter state encoding shared by the
// drawing controllers and the VGA plot-port arbiter.
package draw_port_arbiter_pkg;

    localparam int unsigned SCREEN_X_W = 8;   // 160 columns
    localparam int unsigned SCREEN_Y_W = 7;   // 120 rows
    localparam int unsigned SCREEN_C_W = 3;

    localparam logic [SCREEN_C_W-1:0] COLOUR_BLACK = 3'b000;
    localparam logic [SCREEN_C_W-1:0] COLOUR_RED   = 3'b100;
    localparam logic [SCREEN_C_W-1:0] COLOUR_WHITE = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/draw_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or
// after ptr, wrapping, returned as a one-hot winner.
module rr_pick #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic             valid
);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] back;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   oh;
    logic              found;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NREQ-1:0];
        oh    = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (rot[k] && !found) begin
                oh[k] = 1'b1;
                found = 1'b1;
            end
        end
        back  = {oh, oh} << ptr;
        win   = back[2*NREQ-1:NREQ];
        valid = |req;
    end

endmodule

// File: rtl/draw_port_arbiter.sv
// Round-robin arbiter sharing the VGA adapter plot port between drawing
// controllers, with a burst cap that forces rotation when others wait.
module draw_port_arbiter
    import draw_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned X_W       = SCREEN_X_W,
    parameter int unsigned Y_W       = SCREEN_Y_W,
    parameter int unsigned C_W       = SCREEN_C_W,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*X_W-1:0] req_x,
    input  logic [NREQ*Y_W-1:0] req_y,
    input  logic [NREQ*C_W-1:0] req_colour,
    input  logic [NREQ-1:0]   req_plot,
    output logic [NREQ-1:0]   gnt,
    output logic [X_W-1:0]    vga_x,
    output logic [Y_W-1:0]    vga_y,
    output logic [C_W-1:0]    vga_colour,
    output logic              vga_plot,
    output logic              busy,
    output logic              violation
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 2);

    arb_state_t        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [NREQ-1:0]   win;
    logic              pick_valid;
    logic              accept;
    logic              owner_req;
    logic              others_wait;
    logic              cap_hit;
    logic [X_W-1:0]    sel_x;
    logic [Y_W-1:0]    sel_y;
    logic [C_W-1:0]    sel_colour;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .win   (win),
        .valid (pick_valid)
    );

    always_comb begin
        win_idx    = '0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (win[k]) win_idx = PTR_W'(k);
            if (gnt[k]) begin
                sel_x      = req_x[k*X_W +: X_W];
                sel_y      = req_y[k*Y_W +: Y_W];
                sel_colour = req_colour[k*C_W +: C_W];
            end
        end
        accept      = |(gnt & req_plot);
        owner_req   = |(gnt & req);
        others_wait = |(req & ~gnt);
        cnt_next    = (burst_cnt == '1) ? burst_cnt : burst_cnt + 1'b1;
        // Saturating count: a waiter arriving after the cap is reached still
        // rotates the grant on the owner's next accepted plot.
        cap_hit     = (MAX_BURST != 0) && accept && (32'(cnt_next) >= MAX_BURST);
        next_ptr    = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            gnt        <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            burst_cnt  <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            violation  <= 1'b0;
        end else begin
            violation <= violation | (|(req_plot & ~gnt));
            vga_plot  <= accept;
            if (accept) begin
                vga_x      <= sel_x;
                vga_y      <= sel_y;
                vga_colour <= sel_colour;
            end
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state     <= ARB_GRANT;
                        gnt       <= win;
                        owner     <= win_idx;
                        burst_cnt <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (accept) burst_cnt <= cnt_next;
                    if (!owner_req || (cap_hit && others_wait)) begin
                        state  <= ARB_GAP;
                        gnt    <= '0;
                        rr_ptr <= next_ptr;
                    end
                end
                ARB_GAP: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == ARB_GRANT);

endmodule
